// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one external combinational integer ALU between two requesters.
//
// Flow per operation:
//   IDLE  : round-robin grant to one valid requester and latch its op/a/b.
//   ISSUE : drive the ALU for one cycle and register its result.
//   RESP  : present the registered result to the owning requester until it takes it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/_ready         request handshake (ready only ever high in IDLE)
//   req{0,1}_op/_a/_b             ALU_OP code and operands from each requester
//   alu_op/alu_a/alu_b            drive the shared ALU (quiet add 0+0 outside ISSUE)
//   alu_result                    combinational result back from the ALU
//   rsp_valid[1:0]                one-hot, bit i = response pending for requester i
//   rsp_ready[1:0]                bit i = requester i takes its response
//   rsp_result, rsp_err           registered result and illegal-op flag
module alu_rr_arbiter #(
  parameter int unsigned DW      = 32,
  parameter int unsigned NUM_OPS = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [3:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [3:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_err
);

  // Codes at or above this limit are rejected without touching the ALU.
  localparam logic [4:0] OpLimit = 5'(NUM_OPS);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;   // requester favoured when both are valid
  logic          gnt_q, gnt_d;   // owner of the in-flight operation
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  logic          err_q, err_d;

  logic          gnt0, gnt1;
  logic          op_illegal;
  logic          rsp_fire;

  // Grant decision: a lone requester wins regardless of the pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign op_illegal = ({1'b0, op_q} >= OpLimit);
  assign rsp_fire   = gnt_q ? rsp_ready[1] : rsp_ready[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt0 || gnt1) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  if (rsp_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: operand latch on grant, result capture in ISSUE.
  always_comb begin
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    err_d = err_q;
    if (gnt0 || gnt1) begin
      gnt_d = gnt1;
      ptr_d = gnt0;  // point at the other requester
      op_d  = gnt1 ? req1_op : req0_op;
      a_d   = gnt1 ? req1_a  : req0_a;
      b_d   = gnt1 ? req1_b  : req0_b;
    end
    if (state_q == StIssue) begin
      res_d = op_illegal ? '0 : alu_result;
      err_d = op_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
      gnt_q <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  // Outputs: ALU sees a quiet add except during a legal ISSUE cycle.
  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    alu_op     = 4'b0000;
    alu_a      = '0;
    alu_b      = '0;
    rsp_valid  = 2'b00;
    if (state_q == StIssue && !op_illegal) begin
      alu_op = op_q;
      alu_a  = a_q;
      alu_b  = b_q;
    end
    if (state_q == StResp) begin
      rsp_valid = gnt_q ? 2'b10 : 2'b01;
    end
  end

  assign rsp_result = res_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a transaction-level model predicts every output each cycle,
// and directed scenarios pin literal values along the way.
module tb_alu_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
  logic [1:0]  rsp_valid, rsp_ready;
  logic        rsp_err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  alu_rr_arbiter #(.DW(32), .NUM_OPS(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  // The shared ALU lives outside the block; 0101 is taken as nor.
  function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  // One pending operation at most; m_age counts cycles since its grant.
  logic        m_on = 1'b0;
  logic        m_pend, m_ptr, m_owner, m_next_err, m_shown_err;
  int          m_age;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_next, m_shown;
  logic [1:0]  m_g;

  function automatic logic [1:0] exp_ready();
    logic [1:0] r;
    r = 2'b00;
    if (!m_pend) begin
      if (req0_valid && (!req1_valid || m_ptr == 1'b0)) r = 2'b01;
      else if (req1_valid) r = 2'b10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_pend = 1'b0; m_ptr = 1'b0;
      m_shown = '0; m_shown_err = 1'b0; m_age = 0;
    end else if (m_on) begin
      if (m_pend) begin
        if (m_age == 0) begin
          m_age = 1; m_shown = m_next; m_shown_err = m_next_err;
        end else if (rsp_ready[m_owner]) begin
          m_pend = 1'b0;
        end
      end else begin
        m_g = exp_ready();
        if (m_g != 2'b00) begin
          m_pend  = 1'b1;
          m_age   = 0;
          m_owner = m_g[1];
          m_op    = m_owner ? req1_op : req0_op;
          m_a     = m_owner ? req1_a  : req0_a;
          m_b     = m_owner ? req1_b  : req0_b;
          m_next_err = (m_op > 4'd8);
          m_next  = m_next_err ? 32'd0 : alu_fn(m_op, m_a, m_b);
          m_ptr   = ~m_owner;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      logic issue_live;
      issue_live = m_pend && m_age == 0 && !m_next_err;
      chk("model req_ready", {30'd0, req1_ready, req0_ready}, {30'd0, exp_ready()});
      chk("model alu_op", {28'd0, alu_op}, issue_live ? {28'd0, m_op} : 32'd0);
      chk("model alu_a", alu_a, issue_live ? m_a : 32'd0);
      chk("model alu_b", alu_b, issue_live ? m_b : 32'd0);
      chk("model rsp_valid", {30'd0, rsp_valid},
          (m_pend && m_age == 1) ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
      chk("model rsp_result", rsp_result, m_shown);
      chk("model rsp_err", {31'd0, rsp_err}, {31'd0, m_shown_err});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    int gcyc[3];
    logic [31:0] lone_exp[3];
    lone_exp[0] = 32'h0000_00F0; lone_exp[1] = 32'd3; lone_exp[2] = 32'd5;

    rst = 1'b1; rsp_ready = 2'b11;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    tick(); tick();
    neg();
    chk("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("reset rsp_result", rsp_result, 32'd0);
    chk("reset alu_op", {28'd0, alu_op}, 32'd0);
    tick();
    rst = 1'b0;

    // Single op: add 5+3.
    req0_valid = 1; req0_op = 4'd0; req0_a = 5; req0_b = 3;
    neg(); chk("single ready0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 0;
    neg();
    chk("single alu_a", alu_a, 32'd5);
    chk("single alu_b", alu_b, 32'd3);
    tick(); neg();
    chk("single rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("single rsp_result", rsp_result, 32'd8);
    chk("single rsp_err", {31'd0, rsp_err}, 32'd0);
    tick(); neg();
    chk("single idle", {30'd0, rsp_valid}, 32'd0);

    // Contention after a fresh reset: grants alternate starting with req0.
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1; req0_op = 4'd1; req0_a = 10; req0_b = 4;
    req1_valid = 1; req1_op = 4'd8; req1_a = 2;  req1_b = 7;
    for (int k = 0; k < 6; k++) begin
      neg(); chk("contend grant", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick(); neg(); tick(); neg();
      chk("contend rsp_valid", {30'd0, rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("contend result", rsp_result, (k % 2 == 0) ? 32'd6 : 32'd1);
      tick();
    end
    req0_valid = 0; req1_valid = 0;

    // Backpressure: sll 0x0F by 4 held while rsp_ready stays low.
    rsp_ready = 2'b00;
    req0_valid = 1; req0_op = 4'd6; req0_a = 32'h0F; req0_b = 4;
    neg(); chk("bp ready0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 0;
    neg(); tick(); neg();
    chk("bp rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("bp result", rsp_result, 32'h0000_00F0);
    req0_valid = 1; req0_op = 4'd0; req1_valid = 1; req1_op = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick(); neg();
      chk("bp hold valid", {30'd0, rsp_valid}, 32'd1);
      chk("bp hold result", rsp_result, 32'h0000_00F0);
      chk("bp no ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    tick(); rsp_ready = 2'b10;
    neg(); tick(); rsp_ready = 2'b01;
    neg(); chk("bp wrong bit ignored", {30'd0, rsp_valid}, 32'd1);
    tick(); req0_valid = 0; req1_valid = 0; rsp_ready = 2'b11;
    neg(); chk("bp released", {30'd0, rsp_valid}, 32'd0);

    // Illegal op from req1.
    tick();
    req1_valid = 1; req1_op = 4'b1011; req1_a = 32'hFFFF_FFFF; req1_b = 5;
    neg(); chk("illegal ready1", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 0;
    neg();
    chk("illegal alu_op", {28'd0, alu_op}, 32'd0);
    chk("illegal alu_a", alu_a, 32'd0);
    tick(); neg();
    chk("illegal rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("illegal result", rsp_result, 32'd0);
    chk("illegal err", {31'd0, rsp_err}, 32'd1);
    tick();

    // Reset while an op is in ISSUE: it must vanish.
    req0_valid = 1; req0_op = 4'd0; req0_a = 1; req0_b = 1;
    neg(); tick(); req0_valid = 0;
    neg(); chk("midop alu_a", alu_a, 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    neg();
    chk("midop alu_a cleared", alu_a, 32'd0);
    chk("midop err cleared", {31'd0, rsp_err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("midop no rsp", {30'd0, rsp_valid}, 32'd0);
      tick(); neg();
    end
    tick();

    // Lone requester 1: and, or, xor back to back.
    req1_valid = 1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin req1_op = 4'd2; req1_a = 32'hF0F0; req1_b = 32'h0FF0; end
        1:       begin req1_op = 4'd3; req1_a = 32'd1;    req1_b = 32'd2;    end
        default: begin req1_op = 4'd4; req1_a = 32'd6;    req1_b = 32'd3;    end
      endcase
      neg(); chk("lone ready1", {30'd0, req1_ready, req0_ready}, 32'd2);
      gcyc[k] = cyc_n;
      if (k > 0) chk("lone spacing", gcyc[k] - gcyc[k-1], 32'd3);
      tick(); neg(); tick(); neg();
      chk("lone result", rsp_result, lone_exp[k]);
      tick();
    end
    req1_valid = 0;
    tick(); tick(); neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares the single combinational integer ALU (4-bit ALU_OP encoding: 0000 add … 1000 slt) between two requesters, e.g. the EX stage helper path and a debug/self-test unit. Arbitrates round-robin, latches the winner's operands, drives the ALU for one cycle, registers the result, and returns it on a valid/ready response channel to the requester that issued it. Sits beside the ALU in the execute region; the ALU itself stays outside this block.

Parameters:
DW, 32, operand/result width.
NUM_OPS, 9, count of legal ALU_OP codes (0000..1000); codes >= NUM_OPS are illegal.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 accepted this cycle.
req0_op  in  4  ALU_OP code from requester 0.
req0_a  in  DW  operand A from requester 0.
req0_b  in  DW  operand B from requester 0 (shift amount for 0110/0111).
req1_valid, req1_ready, req1_op, req1_a, req1_b: same as above for requester 1.
alu_op  out  4  to ALU ALU_OP.
alu_a  out  DW  to ALU operand A.
alu_b  out  DW  to ALU operand B.
alu_result  in  DW  from ALU, combinational from alu_op/alu_a/alu_b.
rsp_valid  out  2  one-hot; bit i = response pending for requester i.
rsp_ready  in  2  bit i = requester i takes its response.
rsp_result  out  DW  registered result.
rsp_err  out  1  response carries an illegal-op error.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, rr priority pointer = 0, req*_ready=0, rsp_valid=00, rsp_result=0, rsp_err=0, alu_op=0000, alu_a=0, alu_b=0. An in-flight transaction is dropped; no response is ever produced for it.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: combinationally assert reqX_ready for exactly one valid requester. If both are valid, grant the one the pointer selects. If only one is valid, grant it regardless of the pointer. On handshake (reqX_valid & reqX_ready), latch op/a/b and the grant index, set pointer = other index, go to ISSUE. ready is never asserted outside IDLE.
- ISSUE (1 cycle): drive alu_op/alu_a/alu_b from the latched values. At the edge, capture alu_result into rsp_result, rsp_err=0, go to RESP.
  - Illegal op (latched op >= NUM_OPS): drive alu_op=0000, alu_a=0, alu_b=0; capture rsp_result=0, rsp_err=1.
- RESP: rsp_valid[grant]=1, other bit 0. rsp_result and rsp_err are held stable. Stay until rsp_ready[grant]=1. rsp_ready on the non-granted bit is ignored. At the edge where rsp_valid[grant] & rsp_ready[grant], go to IDLE; rsp_valid goes 0 next cycle.
- Outside ISSUE, alu_op/alu_a/alu_b = 0000/0/0, so the shared ALU sees a quiet add.
- Latency: handshake at edge N, ISSUE in cycle N+1, rsp_valid high in cycle N+2. Minimum occupancy is 3 cycles per op: a new grant is possible in the cycle after the response handshake.
- Fairness: under continuous contention grants alternate 0,1,0,1…. The pointer updates only on grant.
- No combinational path from alu_result to any output. rsp_* come only from registers. req*_ready depends only on state, pointer and req*_valid.

Test Plan:
- Single op: after reset, req0 add a=5 b=3 → req0_ready=1 same cycle; alu_op=0000 alu_a=5 alu_b=3 next cycle; rsp_valid=01, rsp_result=8, rsp_err=0 the cycle after.
- Simultaneous contention: both valid after reset (req0 sub 10,4; req1 slt 2,7) → req0 granted first (rsp_result=6). Then req1 (rsp_result=1, rsp_valid=10). Both held valid for 4 more ops → grants strictly alternate.
- Backpressure: rsp_ready=00 for 5 cycles after rsp_valid=01 with result 0x0000_00F0 (sll 0x0F,4) → rsp_valid, rsp_result stable, req0_ready/req1_ready=0 throughout. rsp_ready=10 (wrong bit) → no effect. rsp_ready=01 → IDLE next cycle.
- Illegal op: req1_op=1011 a=0xFFFF_FFFF → alu_op=0000 alu_a=0 during ISSUE; rsp_valid=10, rsp_result=0, rsp_err=1.
- Reset mid-op: assert rst during ISSUE → next cycle all outputs at reset values, no rsp_valid ever for that op. The next req1-only request is granted immediately (pointer=0 but req0 idle).
- Lone requester: req1 issues 3 consecutive ops (and 0xF0F0,0x0FF0; or 1,2; xor 6,3) with rsp_ready=11 → results 0x00F0, 3, 5, each 3 cycles apart.
